res_station: RTL and testbench

RES_STATION -- requirements
Module: res_station

---
 rtl/res_station.sv | 164 ++++++++++++++++
 tb/tb_res_station.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/res_station.sv
// Reservation station: holds renamed instructions until both source operands are
// available, captures operands from the common data bus, and issues the
// lowest-index ready entry to the execute stage.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   wr_en, wr_addr           rename write strobe and target entry
//   wr_qj/wr_qk, wr_vj/wr_vk source producer tags (0 = present) and values
//   wr_a, wr_op              immediate/address field and opcode
//   cdb_valid/tag/data       result broadcast (tag 0 is never a producer)
//   issue_valid/ready        issue handshake; issue_valid is combinational
//   issue_op/vj/vk/a/idx     payload of the lowest-index ready entry
//   count, full              busy-entry count and full flag
//   wr_err                   one-cycle pulse after a write hits a busy entry
module res_station #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 6,
  parameter int unsigned OP_W  = 16,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [TAG_W-1:0] wr_qj,
  input  logic [TAG_W-1:0] wr_qk,
  input  logic [31:0]      wr_vj,
  input  logic [31:0]      wr_vk,
  input  logic [31:0]      wr_a,
  input  logic [OP_W-1:0]  wr_op,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [OP_W-1:0]  issue_op,
  output logic [31:0]      issue_vj,
  output logic [31:0]      issue_vk,
  output logic [31:0]      issue_a,
  output logic [IDX_W-1:0] issue_idx,
  output logic [IDX_W:0]   count,
  output logic             full,
  output logic             wr_err
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;
  logic [DEPTH-1:0] ready;
  logic [OP_W-1:0]  op_q [DEPTH];
  logic [TAG_W-1:0] qj_q [DEPTH];
  logic [TAG_W-1:0] qk_q [DEPTH];
  logic [31:0]      vj_q [DEPTH];
  logic [31:0]      vk_q [DEPTH];
  logic [31:0]      a_q  [DEPTH];

  logic             any_ready;
  logic [IDX_W-1:0] sel;
  logic             fire;
  logic             cdb_hit;
  logic             wr_acc;
  logic [TAG_W-1:0] qj_in;
  logic [TAG_W-1:0] qk_in;
  logic [31:0]      vj_in;
  logic [31:0]      vk_in;
  logic [CNT_W-1:0] count_nxt;

  // Ready only from registered state, so new or woken entries wait one cycle.
  always_comb begin
    ready = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy[i] && (qj_q[i] == '0) && (qk_q[i] == '0);
    end
  end

  // Lowest-index ready entry wins.
  always_comb begin
    any_ready = 1'b0;
    sel       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && !any_ready) begin
        any_ready = 1'b1;
        sel       = IDX_W'(i);
      end
    end
  end

  assign issue_valid = any_ready;
  assign issue_idx   = sel;
  assign issue_op    = op_q[sel];
  assign issue_vj    = vj_q[sel];
  assign issue_vk    = vk_q[sel];
  assign issue_a     = a_q[sel];

  assign fire    = any_ready && issue_ready;
  assign cdb_hit = cdb_valid && (cdb_tag != '0);
  // An entry being issued this cycle is free for the incoming write.
  assign wr_acc  = wr_en && (!busy[wr_addr] || (fire && (sel == wr_addr)));

  // Same-cycle CDB bypass into the incoming write.
  always_comb begin
    qj_in = wr_qj;
    vj_in = wr_vj;
    qk_in = wr_qk;
    vk_in = wr_vk;
    if (cdb_hit && (wr_qj == cdb_tag)) begin
      qj_in = '0;
      vj_in = cdb_data;
    end
    if (cdb_hit && (wr_qk == cdb_tag)) begin
      qk_in = '0;
      vk_in = cdb_data;
    end
  end

  // Issue clears before write sets, so a same-entry write/issue ends busy.
  always_comb begin
    busy_nxt = busy;
    if (fire) busy_nxt[sel] = 1'b0;
    if (wr_acc) busy_nxt[wr_addr] = 1'b1;
  end

  assign count_nxt = count + CNT_W'(wr_acc) - CNT_W'(fire);

  // Control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= '0;
      count  <= '0;
      full   <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      busy   <= busy_nxt;
      count  <= count_nxt;
      full   <= (count_nxt == CNT_W'(DEPTH));
      wr_err <= wr_en && !wr_acc;
    end
  end

  // Entry payload: no reset, only meaningful while busy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_acc && (wr_addr == IDX_W'(i))) begin
        op_q[i] <= wr_op;
        a_q[i]  <= wr_a;
        qj_q[i] <= qj_in;
        vj_q[i] <= vj_in;
        qk_q[i] <= qk_in;
        vk_q[i] <= vk_in;
      end else begin
        if (cdb_hit && busy[i] && (qj_q[i] == cdb_tag)) begin
          qj_q[i] <= '0;
          vj_q[i] <= cdb_data;
        end
        if (cdb_hit && busy[i] && (qk_q[i] == cdb_tag)) begin
          qk_q[i] <= '0;
          vk_q[i] <= cdb_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_res_station.sv
module tb_res_station;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned TAG_W = 6;
  localparam int unsigned OP_W  = 16;
  localparam int unsigned IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [TAG_W-1:0] wr_qj, wr_qk;
  logic [31:0]      wr_vj, wr_vk, wr_a;
  logic [OP_W-1:0]  wr_op;
  logic             cdb_valid;
  logic [TAG_W-1:0] cdb_tag;
  logic [31:0]      cdb_data;
  logic             issue_valid, issue_ready;
  logic [OP_W-1:0]  issue_op;
  logic [31:0]      issue_vj, issue_vk, issue_a;
  logic [IDX_W-1:0] issue_idx;
  logic [IDX_W:0]   count;
  logic             full, wr_err;

  int total = 0;
  int bad   = 0;

  res_station #(.DEPTH(DEPTH), .TAG_W(TAG_W), .OP_W(OP_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_qj(wr_qj), .wr_qk(wr_qk),
    .wr_vj(wr_vj), .wr_vk(wr_vk), .wr_a(wr_a), .wr_op(wr_op),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_vj(issue_vj), .issue_vk(issue_vk),
    .issue_a(issue_a), .issue_idx(issue_idx),
    .count(count), .full(full), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int addr, input int qj, input int qk,
                          input logic [31:0] vj, input logic [31:0] vk,
                          input logic [31:0] a, input int op);
    wr_en   = 1'b1;
    wr_addr = IDX_W'(addr);
    wr_qj   = TAG_W'(qj);
    wr_qk   = TAG_W'(qk);
    wr_vj   = vj;
    wr_vk   = vk;
    wr_a    = a;
    wr_op   = OP_W'(op);
  endtask

  task automatic drive_cdb(input logic v, input int tag, input logic [31:0] data);
    cdb_valid = v;
    cdb_tag   = TAG_W'(tag);
    cdb_data  = data;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_qj = '0; wr_qk = '0;
    wr_vj = '0; wr_vk = '0; wr_a = '0; wr_op = '0; issue_ready = 1'b0;
    drive_cdb(1'b0, 0, 32'h0);
    step(); step();
    rst = 1'b0;
    total++; if (count !== 4'd0) begin $display("FAIL reset_count got=%0d exp=0", count); bad++; end
    total++; if (full !== 1'b0) begin $display("FAIL reset_full got=%b exp=0", full); bad++; end
    total++; if (wr_err !== 1'b0) begin $display("FAIL reset_wr_err got=%b exp=0", wr_err); bad++; end
    total++; if (issue_valid !== 1'b0) begin $display("FAIL reset_issue_valid got=%b exp=0", issue_valid); bad++; end
  endtask

  task automatic test_no_dep();
    drive_wr(2, 0, 0, 32'd5, 32'd7, 32'h40, 'h11);
    total++; if (issue_valid !== 1'b0) begin $display("FAIL nodep_same_cycle got=%b exp=0", issue_valid); bad++; end
    step();
    wr_en = 1'b0;
    total++; if (issue_valid !== 1'b1) begin $display("FAIL nodep_valid got=%b exp=1", issue_valid); bad++; end
    total++; if (issue_idx !== 3'd2) begin $display("FAIL nodep_idx got=%0d exp=2", issue_idx); bad++; end
    total++; if (issue_vj !== 32'd5) begin $display("FAIL nodep_vj got=%h exp=5", issue_vj); bad++; end
    total++; if (issue_vk !== 32'd7) begin $display("FAIL nodep_vk got=%h exp=7", issue_vk); bad++; end
    total++; if (issue_op !== 16'h11) begin $display("FAIL nodep_op got=%h exp=11", issue_op); bad++; end
    total++; if (issue_a !== 32'h40) begin $display("FAIL nodep_a got=%h exp=40", issue_a); bad++; end
    total++; if (count !== 4'd1) begin $display("FAIL nodep_count1 got=%0d exp=1", count); bad++; end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    total++; if (count !== 4'd0) begin $display("FAIL nodep_count0 got=%0d exp=0", count); bad++; end
    total++; if (issue_valid !== 1'b0) begin $display("FAIL nodep_drained got=%b exp=0", issue_valid); bad++; end
  endtask

  task automatic test_wakeup();
    drive_wr(0, 9, 0, 32'h0, 32'd3, 32'h0, 'h22);
    step();
    wr_en = 1'b0;
    total++; if (issue_valid !== 1'b0) begin $display("FAIL wake_wait1 got=%b exp=0", issue_valid); bad++; end
    step();
    total++; if (issue_valid !== 1'b0) begin $display("FAIL wake_wait2 got=%b exp=0", issue_valid); bad++; end
    drive_cdb(1'b1, 9, 32'hABCD);
    total++; if (issue_valid !== 1'b0) begin $display("FAIL wake_cdb_cycle got=%b exp=0", issue_valid); bad++; end
    step();
    drive_cdb(1'b0, 0, 32'h0);
    total++; if (issue_valid !== 1'b1) begin $display("FAIL wake_valid got=%b exp=1", issue_valid); bad++; end
    total++; if (issue_idx !== 3'd0) begin $display("FAIL wake_idx got=%0d exp=0", issue_idx); bad++; end
    total++; if (issue_vj !== 32'hABCD) begin $display("FAIL wake_vj got=%h exp=abcd", issue_vj); bad++; end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    total++; if (count !== 4'd0) begin $display("FAIL wake_count got=%0d exp=0", count); bad++; end
  endtask

  task automatic test_bypass();
    drive_wr(5, 0, 4, 32'd1, 32'd2, 32'h0, 'h33);
    drive_cdb(1'b1, 4, 32'h77);
    step();
    wr_en = 1'b0;
    drive_cdb(1'b0, 0, 32'h0);
    total++; if (issue_valid !== 1'b1) begin $display("FAIL byp_valid got=%b exp=1", issue_valid); bad++; end
    total++; if (issue_idx !== 3'd5) begin $display("FAIL byp_idx got=%0d exp=5", issue_idx); bad++; end
    total++; if (issue_vk !== 32'h77) begin $display("FAIL byp_vk got=%h exp=77", issue_vk); bad++; end
    total++; if (issue_vj !== 32'd1) begin $display("FAIL byp_vj got=%h exp=1", issue_vj); bad++; end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    // Tag 0 broadcast must not touch present operands, in the write or in storage.
    drive_wr(1, 0, 6, 32'h10, 32'h0, 32'h0, 'h44);
    drive_cdb(1'b1, 0, 32'hDEAD);
    step();
    wr_en = 1'b0;
    drive_cdb(1'b1, 0, 32'hBEEF);
    total++; if (issue_valid !== 1'b0) begin $display("FAIL tag0_nowake got=%b exp=0", issue_valid); bad++; end
    step();
    drive_cdb(1'b1, 6, 32'h66);
    total++; if (issue_valid !== 1'b0) begin $display("FAIL tag0_still got=%b exp=0", issue_valid); bad++; end
    step();
    drive_cdb(1'b0, 0, 32'h0);
    total++; if (issue_valid !== 1'b1) begin $display("FAIL tag0_valid got=%b exp=1", issue_valid); bad++; end
    total++; if (issue_vj !== 32'h10) begin $display("FAIL tag0_vj got=%h exp=10", issue_vj); bad++; end
    total++; if (issue_vk !== 32'h66) begin $display("FAIL tag0_vk got=%h exp=66", issue_vk); bad++; end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    total++; if (count !== 4'd0) begin $display("FAIL byp_count got=%0d exp=0", count); bad++; end
  endtask

  task automatic test_full();
    int exp_cnt;
    for (int i = 0; i < 8; i++) begin
      drive_wr(i, 0, 0, 32'(i * 256), 32'(i), 32'h0, i);
      step();
    end
    wr_en = 1'b0;
    total++; if (count !== 4'd8) begin $display("FAIL full_count got=%0d exp=8", count); bad++; end
    total++; if (full !== 1'b1) begin $display("FAIL full_flag got=%b exp=1", full); bad++; end
    issue_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      total++; if (issue_valid !== 1'b1) begin $display("FAIL prio_valid k=%0d got=%b exp=1", k, issue_valid); bad++; end
      total++; if (issue_idx !== 3'(k)) begin $display("FAIL prio_idx got=%0d exp=%0d", issue_idx, k); bad++; end
      total++; if (issue_vj !== 32'(k * 256)) begin $display("FAIL prio_vj k=%0d got=%h exp=%h", k, issue_vj, k * 256); bad++; end
      // Rewrite entry 0 while it issues; a dependency keeps it out of the order.
      if (k == 0) drive_wr(0, 12, 0, 32'hF00, 32'h0, 32'h0, 'h3F);
      step();
      wr_en = 1'b0;
      exp_cnt = (k == 0) ? 8 : 8 - k;
      if (k == 0) begin
        total++; if (wr_err !== 1'b0) begin $display("FAIL same_entry_wr_err got=%b exp=0", wr_err); bad++; end
        total++; if (full !== 1'b1) begin $display("FAIL same_entry_full got=%b exp=1", full); bad++; end
      end
      total++; if (count !== 4'(exp_cnt)) begin $display("FAIL drain_count k=%0d got=%0d exp=%0d", k, count, exp_cnt); bad++; end
    end
    total++; if (issue_valid !== 1'b0) begin $display("FAIL drain_waiting got=%b exp=0", issue_valid); bad++; end
    drive_cdb(1'b1, 12, 32'h1234);
    step();
    drive_cdb(1'b0, 0, 32'h0);
    total++; if (issue_idx !== 3'd0 || issue_valid !== 1'b1) begin $display("FAIL rewritten_issue got=%b/%0d exp=1/0", issue_valid, issue_idx); bad++; end
    total++; if (issue_vj !== 32'h1234) begin $display("FAIL rewritten_vj got=%h exp=1234", issue_vj); bad++; end
    total++; if (issue_op !== 16'h3F) begin $display("FAIL rewritten_op got=%h exp=3f", issue_op); bad++; end
    step();
    issue_ready = 1'b0;
    total++; if (count !== 4'd0) begin $display("FAIL full_end_count got=%0d exp=0", count); bad++; end
  endtask

  task automatic test_illegal();
    drive_wr(3, 0, 0, 32'h33, 32'h3, 32'h0, 'h55);
    step();
    drive_wr(3, 0, 0, 32'h99, 32'h9, 32'h0, 'h66);
    step();
    wr_en = 1'b0;
    total++; if (wr_err !== 1'b1) begin $display("FAIL illegal_err got=%b exp=1", wr_err); bad++; end
    total++; if (count !== 4'd1) begin $display("FAIL illegal_count got=%0d exp=1", count); bad++; end
    step();
    total++; if (wr_err !== 1'b0) begin $display("FAIL illegal_pulse got=%b exp=0", wr_err); bad++; end
    total++; if (issue_vj !== 32'h33) begin $display("FAIL illegal_vj got=%h exp=33", issue_vj); bad++; end
    total++; if (issue_op !== 16'h55) begin $display("FAIL illegal_op got=%h exp=55", issue_op); bad++; end
    issue_ready = 1'b1;
    step();
    issue_ready = 1'b0;
    total++; if (count !== 4'd0) begin $display("FAIL illegal_drain got=%0d exp=0", count); bad++; end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      drive_wr(i, (i % 2 == 0) ? 0 : 20, 0, 32'(i), 32'h0, 32'h0, i);
      step();
    end
    wr_en = 1'b0;
    total++; if (count !== 4'd5) begin $display("FAIL mid_count5 got=%0d exp=5", count); bad++; end
    rst = 1'b1;
    drive_wr(5, 0, 0, 32'h5, 32'h0, 32'h0, 5);
    drive_cdb(1'b1, 20, 32'hCAFE);
    step();
    rst = 1'b0;
    wr_en = 1'b0;
    total++; if (count !== 4'd0) begin $display("FAIL mid_count0 got=%0d exp=0", count); bad++; end
    total++; if (issue_valid !== 1'b0) begin $display("FAIL mid_valid got=%b exp=0", issue_valid); bad++; end
    total++; if (full !== 1'b0) begin $display("FAIL mid_full got=%b exp=0", full); bad++; end
    issue_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++; if (issue_valid !== 1'b0) begin $display("FAIL stale_issue c=%0d got=%b exp=0", c, issue_valid); bad++; end
    end
    drive_cdb(1'b0, 0, 32'h0);
    issue_ready = 1'b0;
    total++; if (count !== 4'd0) begin $display("FAIL mid_final_count got=%0d exp=0", count); bad++; end
  endtask

  initial begin
    test_reset();
    test_no_dep();
    test_wakeup();
    test_bypass();
    test_full();
    test_illegal();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
